// File: rtl/score_board_pkg.sv
// Shared types and limits for the scoreboard digit path.
package score_board_pkg;

   localparam int SC_MAX     = 9999;
   localparam int LV_MAX     = 99;
   localparam int BCD_DIGITS = 4;

   typedef struct packed {
      logic [3:0] tho;
      logic [3:0] hun;
      logic [3:0] ten;
      logic [3:0] uni;
   } bcd4_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONV_LV = 3'd1,
      CONV_TR = 3'd2,
      CONV_SC = 3'd3,
      COMMIT  = 3'd4
   } sched_state_t;

   // One double-dabble iteration: correct every nibble >= 5, then shift in bit_in.
   function automatic bcd4_t bcd_shift(input bcd4_t b, input logic bit_in);
      logic [15:0] v;
      v = b;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         if (v[i*4 +: 4] >= 4'd5) begin
            v[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
         end
      end
      return bcd4_t'({v[14:0], bit_in});
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one load cycle, then BIN_W shift iterations.
// done and bcd are decoded during the final iteration so the caller can capture
// the finished value and chain the next job without an idle cycle.
module bin2bcd_serial
   import score_board_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             done,
   output bcd4_t            bcd
);

   logic [BIN_W-1:0] shreg;
   bcd4_t            acc;
   bcd4_t            acc_next;
   logic [3:0]       iter;
   logic             running;

   assign acc_next = bcd_shift(acc, shreg[BIN_W-1]);
   assign done     = running && (iter == 4'(BIN_W-1));
   assign bcd      = acc_next;

   // Load on start, otherwise shift one binary bit per cycle while running.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shreg   <= '0;
         acc     <= '0;
         iter    <= '0;
         running <= 1'b0;
      end else if (start) begin
         shreg   <= bin;
         acc     <= '0;
         iter    <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc   <= acc_next;
         shreg <= {shreg[BIN_W-2:0], 1'b0};
         iter  <= iter + 4'd1;
         if (done) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/score_bcd_scheduler.sv
// Shares one serial BCD converter between level, target and score; converts all
// three once per frame and publishes the ten digits together in COMMIT.
module score_bcd_scheduler
   import score_board_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int SC_MAX = score_board_pkg::SC_MAX,
   parameter int LV_MAX = score_board_pkg::LV_MAX
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             startOfFrame,
   input  logic [BIN_W-1:0] level,
   input  logic [BIN_W-1:0] score,
   input  logic [BIN_W-1:0] target,
   output logic [3:0]       lv_ten,
   output logic [3:0]       lv_uni,
   output logic [3:0]       tr_tho,
   output logic [3:0]       tr_hun,
   output logic [3:0]       tr_ten,
   output logic [3:0]       tr_uni,
   output logic [3:0]       sc_tho,
   output logic [3:0]       sc_hun,
   output logic [3:0]       sc_ten,
   output logic [3:0]       sc_uni,
   output logic             digits_valid,
   output logic             busy
);

   sched_state_t     state;
   logic             conv_start;
   logic             conv_done;
   bcd4_t            conv_bcd;
   logic [BIN_W-1:0] conv_bin;
   logic [BIN_W-1:0] snap_lv;
   logic [BIN_W-1:0] snap_tr;
   logic [BIN_W-1:0] snap_sc;
   logic [7:0]       shadow_lv;
   bcd4_t            shadow_tr;
   bcd4_t            shadow_sc;

   // Converter input follows the job currently owned by the FSM.
   always_comb begin
      conv_bin = snap_sc;
      case (state)
         CONV_LV: conv_bin = snap_lv;
         CONV_TR: conv_bin = snap_tr;
         default: conv_bin = snap_sc;
      endcase
   end

   bin2bcd_serial #(
      .BIN_W (BIN_W)
   ) u_conv (
      .clk    (clk),
      .resetN (resetN),
      .start  (conv_start),
      .bin    (conv_bin),
      .done   (conv_done),
      .bcd    (conv_bcd)
   );

   // Round sequencing: snapshot, three chained conversions, atomic commit.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         conv_start   <= 1'b0;
         busy         <= 1'b0;
         digits_valid <= 1'b0;
         snap_lv      <= '0;
         snap_tr      <= '0;
         snap_sc      <= '0;
         shadow_lv    <= '0;
         shadow_tr    <= '0;
         shadow_sc    <= '0;
         lv_ten       <= '0;
         lv_uni       <= '0;
         tr_tho       <= '0;
         tr_hun       <= '0;
         tr_ten       <= '0;
         tr_uni       <= '0;
         sc_tho       <= '0;
         sc_hun       <= '0;
         sc_ten       <= '0;
         sc_uni       <= '0;
      end else begin
         conv_start <= 1'b0;
         case (state)
            IDLE: begin
               if (startOfFrame) begin
                  snap_lv    <= (level  > BIN_W'(LV_MAX)) ? BIN_W'(LV_MAX) : level;
                  snap_tr    <= (target > BIN_W'(SC_MAX)) ? BIN_W'(SC_MAX) : target;
                  snap_sc    <= (score  > BIN_W'(SC_MAX)) ? BIN_W'(SC_MAX) : score;
                  busy       <= 1'b1;
                  conv_start <= 1'b1;
                  state      <= CONV_LV;
               end
            end
            CONV_LV: begin
               if (conv_done) begin
                  shadow_lv  <= {conv_bcd.ten, conv_bcd.uni};
                  conv_start <= 1'b1;
                  state      <= CONV_TR;
               end
            end
            CONV_TR: begin
               if (conv_done) begin
                  shadow_tr  <= conv_bcd;
                  conv_start <= 1'b1;
                  state      <= CONV_SC;
               end
            end
            CONV_SC: begin
               if (conv_done) begin
                  shadow_sc <= conv_bcd;
                  state     <= COMMIT;
               end
            end
            COMMIT: begin
               lv_ten       <= shadow_lv[7:4];
               lv_uni       <= shadow_lv[3:0];
               tr_tho       <= shadow_tr.tho;
               tr_hun       <= shadow_tr.hun;
               tr_ten       <= shadow_tr.ten;
               tr_uni       <= shadow_tr.uni;
               sc_tho       <= shadow_sc.tho;
               sc_hun       <= shadow_sc.hun;
               sc_ten       <= shadow_sc.ten;
               sc_uni       <= shadow_sc.uni;
               digits_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Directed bench for score_bcd_scheduler: reset, nominal, saturation,
// snapshot/atomicity, back-to-back and mid-round reset.
module tb_score_bcd_scheduler;

   logic        clk;
   logic        resetN;
   logic        startOfFrame;
   logic [13:0] level;
   logic [13:0] score;
   logic [13:0] target;
   logic [3:0]  lv_ten, lv_uni;
   logic [3:0]  tr_tho, tr_hun, tr_ten, tr_uni;
   logic [3:0]  sc_tho, sc_hun, sc_ten, sc_uni;
   logic        digits_valid;
   logic        busy;

   logic [7:0]  lv;
   logic [15:0] tr;
   logic [15:0] sc;

   int n_cmp  = 0;
   int n_fail = 0;

   assign lv = {lv_ten, lv_uni};
   assign tr = {tr_tho, tr_hun, tr_ten, tr_uni};
   assign sc = {sc_tho, sc_hun, sc_ten, sc_uni};

   score_bcd_scheduler #(
      .BIN_W  (14),
      .SC_MAX (9999),
      .LV_MAX (99)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .level        (level),
      .score        (score),
      .target       (target),
      .lv_ten       (lv_ten),
      .lv_uni       (lv_uni),
      .tr_tho       (tr_tho),
      .tr_hun       (tr_hun),
      .tr_ten       (tr_ten),
      .tr_uni       (tr_uni),
      .sc_tho       (sc_tho),
      .sc_hun       (sc_hun),
      .sc_ten       (sc_ten),
      .sc_uni       (sc_uni),
      .digits_valid (digits_valid),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      level        = '0;
      score        = '0;
      target       = '0;

      // Reset state
      #3;
      chk("rst_lv", 32'(lv), 32'h0);
      chk("rst_tr", 32'(tr), 32'h0);
      chk("rst_sc", 32'(sc), 32'h0);
      chk("rst_valid", 32'(digits_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      repeat (2) tick();
      resetN = 1'b1;
      repeat (5) tick();
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_valid", 32'(digits_valid), 32'h0);

      // Nominal round: 3 / 650 / 1234
      level = 14'd3; target = 14'd650; score = 14'd1234;
      startOfFrame = 1'b1;
      tick();                       // E0
      startOfFrame = 1'b0;
      chk("nom_busy_e0", 32'(busy), 32'h1);
      repeat (45) tick();           // E45
      chk("nom_busy_e45", 32'(busy), 32'h1);
      chk("nom_valid_e45", 32'(digits_valid), 32'h0);
      chk("nom_sc_e45", 32'(sc), 32'h0);
      tick();                       // E46
      chk("nom_lv", 32'(lv), 32'h03);
      chk("nom_tr", 32'(tr), 32'h0650);
      chk("nom_sc", 32'(sc), 32'h1234);
      chk("nom_valid", 32'(digits_valid), 32'h1);
      chk("nom_busy", 32'(busy), 32'h0);
      tick();

      // Saturation: 150 / 16383 / 12000
      level = 14'd150; target = 14'd16383; score = 14'd12000;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      repeat (45) tick();
      chk("sat_sc_hold", 32'(sc), 32'h1234);
      tick();
      chk("sat_lv", 32'(lv), 32'h99);
      chk("sat_tr", 32'(tr), 32'h9999);
      chk("sat_sc", 32'(sc), 32'h9999);
      tick();

      // Snapshot and atomicity: score changes mid-round
      level = 14'd3; target = 14'd650; score = 14'd1234;
      startOfFrame = 1'b1;
      tick();                       // E0
      startOfFrame = 1'b0;
      repeat (10) tick();           // E10
      score = 14'd5678;
      repeat (35) tick();           // E45
      chk("snap_sc_hold", 32'(sc), 32'h9999);
      chk("snap_tr_hold", 32'(tr), 32'h9999);
      startOfFrame = 1'b1;          // held across E46 (ignored) and E47 (accepted)
      tick();                       // E46
      chk("snap_sc", 32'(sc), 32'h1234);
      chk("snap_tr", 32'(tr), 32'h0650);
      chk("snap_lv", 32'(lv), 32'h03);
      chk("b2b_busy_e46", 32'(busy), 32'h0);
      tick();                       // E47
      startOfFrame = 1'b0;
      chk("b2b_busy_e47", 32'(busy), 32'h1);
      repeat (45) tick();           // E92
      chk("b2b_busy_e92", 32'(busy), 32'h1);
      chk("b2b_sc_hold", 32'(sc), 32'h1234);
      tick();                       // E93
      chk("b2b_busy_e93", 32'(busy), 32'h0);
      chk("b2b_sc", 32'(sc), 32'h5678);
      tick();

      // Reset mid-round
      level = 14'd42; target = 14'd1000; score = 14'd7;
      startOfFrame = 1'b1;
      tick();                       // E0
      startOfFrame = 1'b0;
      repeat (30) tick();           // E30
      resetN = 1'b0;
      #1;
      chk("mrst_lv", 32'(lv), 32'h0);
      chk("mrst_tr", 32'(tr), 32'h0);
      chk("mrst_sc", 32'(sc), 32'h0);
      chk("mrst_valid", 32'(digits_valid), 32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      #3;
      resetN = 1'b1;
      tick();
      startOfFrame = 1'b1;
      tick();                       // E0
      startOfFrame = 1'b0;
      repeat (45) tick();
      chk("fresh_valid_e45", 32'(digits_valid), 32'h0);
      tick();                       // E46
      chk("fresh_lv", 32'(lv), 32'h42);
      chk("fresh_tr", 32'(tr), 32'h1000);
      chk("fresh_sc", 32'(sc), 32'h0007);
      chk("fresh_valid", 32'(digits_valid), 32'h1);
      chk("fresh_busy", 32'(busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
